// File: rtl/mass_stats_accum.sv
// Per-frame mass statistics of a binarised raster pixel stream:
// count, bounding box and centroid sums, one record per frame.
module mass_stats_accum #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W * IMG_H + 1),
    localparam int SW = XW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [7:0]    dataEncoded,
    input  logic          finallydone,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [CW-1:0] mass_count,
    output logic [XW-1:0] min_x,
    output logic [XW-1:0] max_x,
    output logic [YW-1:0] min_y,
    output logic [YW-1:0] max_y,
    output logic [SW-1:0] sum_x,
    output logic [SW-1:0] sum_y,
    output logic          empty,
    output logic          short_frame,
    output logic          drop_err,
    output logic          busy
);

    localparam logic [XW-1:0] XMAX   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YMAX   = YW'(IMG_H - 1);
    localparam logic [CW-1:0] NPIX_C = CW'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic          r_fd_q;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_pix;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_sx;
    logic [SW-1:0] r_sy;
    logic [XW-1:0] r_minx;
    logic [XW-1:0] r_maxx;
    logic [YW-1:0] r_miny;
    logic [YW-1:0] r_maxy;

    logic          w_fd_rise;
    logic          w_take;
    logic          w_fg;
    logic          w_load;
    logic          w_hs;
    logic [XW-1:0] w_x_nx;
    logic [YW-1:0] w_y_nx;
    logic [CW-1:0] w_pix_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [SW-1:0] w_sx_nx;
    logic [SW-1:0] w_sy_nx;
    logic [XW-1:0] w_minx_nx;
    logic [XW-1:0] w_maxx_nx;
    logic [YW-1:0] w_miny_nx;
    logic [YW-1:0] w_maxy_nx;

    assign w_fd_rise = finallydone & ~r_fd_q;
    assign w_take    = we & (r_state != S_HOLD);
    // Pixels beyond a full frame only advance position, never the stats.
    assign w_fg      = w_take & dataEncoded[7] & (r_pix != NPIX_C);
    assign w_load    = w_fd_rise & (r_state != S_HOLD);
    assign w_hs      = res_valid & res_ready;
    assign busy      = (r_state == S_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_fd_q  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fd_q  <= finallydone;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nx = S_HOLD;
                end else if (we) begin
                    w_state_nx = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_load) begin
                    w_state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_hs) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_x_nx    = r_x;
        w_y_nx    = r_y;
        w_pix_nx  = r_pix;
        w_cnt_nx  = r_cnt;
        w_sx_nx   = r_sx;
        w_sy_nx   = r_sy;
        w_minx_nx = r_minx;
        w_maxx_nx = r_maxx;
        w_miny_nx = r_miny;
        w_maxy_nx = r_maxy;
        if (w_take) begin
            if (r_x == XMAX) begin
                w_x_nx = '0;
                w_y_nx = (r_y == YMAX) ? '0 : r_y + 1'b1;
            end else begin
                w_x_nx = r_x + 1'b1;
            end
            if (r_pix != NPIX_C) begin
                w_pix_nx = r_pix + 1'b1;
            end
        end
        if (w_fg) begin
            w_cnt_nx = r_cnt + 1'b1;
            w_sx_nx  = r_sx + SW'(r_x);
            w_sy_nx  = r_sy + SW'(r_y);
            // First foreground pixel seeds the box; the reset zeros are not real bounds.
            if (r_cnt == '0) begin
                w_minx_nx = r_x;
                w_maxx_nx = r_x;
                w_miny_nx = r_y;
                w_maxy_nx = r_y;
            end else begin
                if (r_x < r_minx) w_minx_nx = r_x;
                if (r_x > r_maxx) w_maxx_nx = r_x;
                if (r_y < r_miny) w_miny_nx = r_y;
                if (r_y > r_maxy) w_maxy_nx = r_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_pix  <= '0;
            r_cnt  <= '0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_minx <= '0;
            r_maxx <= '0;
            r_miny <= '0;
            r_maxy <= '0;
        end else if (w_hs) begin
            r_x    <= '0;
            r_y    <= '0;
            r_pix  <= '0;
            r_cnt  <= '0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_minx <= '0;
            r_maxx <= '0;
            r_miny <= '0;
            r_maxy <= '0;
        end else begin
            r_x    <= w_x_nx;
            r_y    <= w_y_nx;
            r_pix  <= w_pix_nx;
            r_cnt  <= w_cnt_nx;
            r_sx   <= w_sx_nx;
            r_sy   <= w_sy_nx;
            r_minx <= w_minx_nx;
            r_maxx <= w_maxx_nx;
            r_miny <= w_miny_nx;
            r_maxy <= w_maxy_nx;
        end
    end

    // Record is built from the next-state values so a pixel in the fd_rise cycle is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            mass_count  <= '0;
            min_x       <= '0;
            max_x       <= '0;
            min_y       <= '0;
            max_y       <= '0;
            sum_x       <= '0;
            sum_y       <= '0;
            empty       <= 1'b0;
            short_frame <= 1'b0;
        end else if (w_load) begin
            res_valid   <= 1'b1;
            mass_count  <= w_cnt_nx;
            min_x       <= w_minx_nx;
            max_x       <= w_maxx_nx;
            min_y       <= w_miny_nx;
            max_y       <= w_maxy_nx;
            sum_x       <= w_sx_nx;
            sum_y       <= w_sy_nx;
            empty       <= (w_cnt_nx == '0);
            short_frame <= (w_pix_nx != NPIX_C);
        end else if (w_hs) begin
            res_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (we && r_state == S_HOLD) begin
            drop_err <= 1'b1;
        end
    end

endmodule
